// File: rtl/col_fifo_readout_arb.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : col_fifo_readout_arb                                       |
// | Description : Round-robin readout arbiter for the column hit FIFOs.      |
// |               Strobes one non-empty column FIFO, captures its hit word,  |
// |               tags it with the column address and presents it on a       |
// |               valid/ready interface. Zero words carry no hit data and    |
// |               are discarded and counted. After every read the            |
// |               arbiter idles for SETTLE cycles so the FIFO's registered   |
// |               data and empty flag are stable before the next scan.       |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module col_fifo_readout_arb #(
  parameter int N_COL  = 8,
  parameter int COL_AW = 3,
  parameter int DW     = 28,
  parameter int SETTLE = 2
) (
  input  logic                  clk_40MHz,
  input  logic                  rst_n,
  input  logic [N_COL-1:0]      col_empty,
  input  logic [N_COL*DW-1:0]   col_data,
  output logic [N_COL-1:0]      col_rd_en,
  output logic [COL_AW+DW-1:0]  out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic                  busy,
  output logic [7:0]            drop_cnt
);

  // Settle counter runs 0 .. SETTLE-1.
  localparam int                c_SCW          = (SETTLE > 1) ? $clog2(SETTLE) : 1;
  localparam logic [c_SCW-1:0]  c_SETTLE_LAST  = c_SCW'(SETTLE - 1);
  localparam logic [COL_AW-1:0] c_LAST_COL     = COL_AW'(N_COL - 1);
  localparam logic [COL_AW:0]   c_NCOL_EXT     = (COL_AW + 1)'(N_COL);
  localparam logic [7:0]        c_DROP_MAX     = 8'hFF;

  typedef enum logic [1:0] {
    ST_SCAN   = 2'd0,
    ST_READ   = 2'd1,
    ST_OUT    = 2'd2,
    ST_SETTLE = 2'd3
  } state_t;

  state_t                r_state;
  state_t                w_state_nxt;

  logic [COL_AW-1:0]     r_ptr;
  logic [COL_AW-1:0]     r_sel;
  logic [N_COL-1:0]      r_rd_en;
  logic                  r_out_valid;
  logic [COL_AW+DW-1:0]  r_out_data;
  logic                  r_busy;
  logic [7:0]            r_drop_cnt;
  logic [c_SCW-1:0]      r_settle_cnt;

  logic [COL_AW-1:0]     w_ptr_nxt;
  logic [COL_AW-1:0]     w_sel_nxt;
  logic [N_COL-1:0]      w_rd_en_nxt;
  logic                  w_valid_nxt;
  logic [COL_AW+DW-1:0]  w_data_nxt;
  logic                  w_busy_nxt;
  logic [7:0]            w_drop_nxt;
  logic [c_SCW-1:0]      w_cnt_nxt;

  logic                  w_found;
  logic [COL_AW-1:0]     w_found_col;
  logic [COL_AW:0]       w_idx;
  logic [DW-1:0]         w_col_word [N_COL];
  logic [DW-1:0]         w_word;
  logic [COL_AW-1:0]     w_ptr_after;

  // Split the flat column data bus into one word per column.
  for (genvar g = 0; g < N_COL; g++) begin : g_unpack
    assign w_col_word[g] = col_data[g*DW +: DW];
  end

  // Only the selected column's word is ever looked at.
  assign w_word      = w_col_word[r_sel];

  // Next scan starts one past the column just served, wrapping at N_COL.
  assign w_ptr_after = (r_sel == c_LAST_COL) ? '0 : r_sel + COL_AW'(1);

  // Round-robin search: first non-empty column at or after r_ptr, with wrap.
  always_comb begin
    w_found     = 1'b0;
    w_found_col = '0;
    w_idx       = '0;
    for (int i = 0; i < N_COL; i++) begin
      w_idx = {1'b0, r_ptr} + (COL_AW + 1)'(i);
      if (w_idx >= c_NCOL_EXT) begin
        w_idx = w_idx - c_NCOL_EXT;
      end
      if (!w_found && !col_empty[w_idx[COL_AW-1:0]]) begin
        w_found     = 1'b1;
        w_found_col = w_idx[COL_AW-1:0];
      end
    end
  end

  // Next-state and next-output logic; every output is computed here and
  // registered below so the ports come straight from flops.
  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_sel_nxt   = r_sel;
    w_rd_en_nxt = '0;
    w_valid_nxt = r_out_valid;
    w_data_nxt  = r_out_data;
    w_drop_nxt  = r_drop_cnt;
    w_cnt_nxt   = r_settle_cnt;

    case (r_state)
      ST_SCAN: begin
        if (w_found) begin
          w_state_nxt = ST_READ;
          w_sel_nxt   = w_found_col;
          w_rd_en_nxt = N_COL'(1) << w_found_col;
        end
      end

      ST_READ: begin
        if (w_word != '0) begin
          w_data_nxt  = {r_sel, w_word};
          w_valid_nxt = 1'b1;
          w_state_nxt = ST_OUT;
        end else begin
          // Empty hit word: drop it and move on as if it were served.
          if (r_drop_cnt != c_DROP_MAX) begin
            w_drop_nxt = r_drop_cnt + 8'd1;
          end
          w_ptr_nxt   = w_ptr_after;
          w_cnt_nxt   = '0;
          w_state_nxt = ST_SETTLE;
        end
      end

      ST_OUT: begin
        // Hold the word until downstream takes it; no reads meanwhile.
        if (out_ready) begin
          w_valid_nxt = 1'b0;
          w_ptr_nxt   = w_ptr_after;
          w_cnt_nxt   = '0;
          w_state_nxt = ST_SETTLE;
        end
      end

      ST_SETTLE: begin
        if (r_settle_cnt == c_SETTLE_LAST) begin
          w_state_nxt = ST_SCAN;
        end else begin
          w_cnt_nxt = r_settle_cnt + c_SCW'(1);
        end
      end

      default: begin
        w_state_nxt = ST_SCAN;
      end
    endcase

    w_busy_nxt = (w_state_nxt != ST_SCAN);
  end

  // State register.
  always_ff @(posedge clk_40MHz) begin
    if (!rst_n) begin
      r_state <= ST_SCAN;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Datapath and output registers; reset discards any held word.
  always_ff @(posedge clk_40MHz) begin
    if (!rst_n) begin
      r_ptr        <= '0;
      r_sel        <= '0;
      r_rd_en      <= '0;
      r_out_valid  <= 1'b0;
      r_out_data   <= '0;
      r_busy       <= 1'b0;
      r_drop_cnt   <= '0;
      r_settle_cnt <= '0;
    end else begin
      r_ptr        <= w_ptr_nxt;
      r_sel        <= w_sel_nxt;
      r_rd_en      <= w_rd_en_nxt;
      r_out_valid  <= w_valid_nxt;
      r_out_data   <= w_data_nxt;
      r_busy       <= w_busy_nxt;
      r_drop_cnt   <= w_drop_nxt;
      r_settle_cnt <= w_cnt_nxt;
    end
  end

  assign col_rd_en = r_rd_en;
  assign out_data  = r_out_data;
  assign out_valid = r_out_valid;
  assign busy      = r_busy;
  assign drop_cnt  = r_drop_cnt;

endmodule
`default_nettype wire

// File: tb/tb_col_fifo_readout_arb.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_col_fifo_readout_arb                                    |
// | Description : Self-checking bench for col_fifo_readout_arb with a        |
// |               transaction-level reference model and emulated FIFOs.      |
// | Revision    : 1.0  initial release                                       |
// +--------------------------------------------------------------------------+
module tb_col_fifo_readout_arb;

  localparam int N_COL  = 8;
  localparam int COL_AW = 3;
  localparam int DW     = 28;
  localparam int SETTLE = 2;

  logic                  clk_40MHz = 1'b0;
  logic                  rst_n;
  logic [N_COL-1:0]      col_empty;
  logic [N_COL*DW-1:0]   col_data;
  logic [N_COL-1:0]      col_rd_en;
  logic [COL_AW+DW-1:0]  out_data;
  logic                  out_valid;
  logic                  out_ready;
  logic                  busy;
  logic [7:0]            drop_cnt;

  col_fifo_readout_arb #(
    .N_COL  (N_COL),
    .COL_AW (COL_AW),
    .DW     (DW),
    .SETTLE (SETTLE)
  ) u_dut (
    .clk_40MHz (clk_40MHz),
    .rst_n     (rst_n),
    .col_empty (col_empty),
    .col_data  (col_data),
    .col_rd_en (col_rd_en),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .busy      (busy),
    .drop_cnt  (drop_cnt)
  );

  initial forever #12 clk_40MHz = ~clk_40MHz;

  // Emulated FIFO contents: word count and constant word per column.
  int             fifo_cnt [N_COL];
  logic [DW-1:0]  words    [N_COL];
  int             served   [$];

  int   n_pass  = 0;
  int   n_total = 0;
  logic chk_en  = 1'b0;

  // Reference model: what the arbiter is doing, at transaction level.
  int                   m_rd   = -1;   // column being read this cycle, -1 none
  bit                   m_held = 1'b0; // a tagged word is waiting downstream
  logic [COL_AW+DW-1:0] m_data = '0;
  int                   m_idle = 0;    // settle cycles still to wait
  int                   m_ptr  = 0;
  int                   m_last = 0;
  int                   m_drop = 0;
  int                   mc;
  logic [DW-1:0]        mw;

  initial forever begin
    @(posedge clk_40MHz);
    if (!rst_n) begin
      m_rd = -1; m_held = 1'b0; m_data = '0; m_idle = 0; m_ptr = 0; m_drop = 0;
    end else if (m_rd >= 0) begin
      mw = col_data[m_rd*DW +: DW];
      if (mw != '0) begin
        m_held = 1'b1;
        m_data = {m_rd[COL_AW-1:0], mw};
        m_last = m_rd;
      end else begin
        m_drop = (m_drop < 255) ? m_drop + 1 : 255;
        m_ptr  = (m_rd + 1) % N_COL;
        m_idle = SETTLE;
      end
      m_rd = -1;
    end else if (m_held) begin
      if (out_ready) begin
        m_held = 1'b0;
        m_ptr  = (m_last + 1) % N_COL;
        m_idle = SETTLE;
      end
    end else if (m_idle > 0) begin
      m_idle = m_idle - 1;
    end else begin
      for (int i = 0; i < N_COL; i++) begin
        mc = (m_ptr + i) % N_COL;
        if (m_rd < 0 && !col_empty[mc]) m_rd = mc;
      end
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic drive_inputs();
    for (int c = 0; c < N_COL; c++) begin
      col_empty[c]           = (fifo_cnt[c] == 0);
      col_data[c*DW +: DW]   = words[c];
    end
  endtask

  // One cycle: compare against the model at the falling edge, then let the
  // emulated FIFOs react to any read strobe.
  task automatic tick();
    logic [N_COL-1:0] exp_rd;
    @(negedge clk_40MHz);
    if (chk_en) begin
      exp_rd = '0;
      if (m_rd >= 0) exp_rd[m_rd] = 1'b1;
      check("cyc_rd_en", 64'(col_rd_en), 64'(exp_rd));
      check("cyc_valid", 64'(out_valid), 64'(m_held));
      check("cyc_busy",  64'(busy), 64'((m_rd >= 0) || m_held || (m_idle > 0)));
      check("cyc_drop",  64'(drop_cnt), 64'(m_drop));
      if (m_held) check("cyc_data", 64'(out_data), 64'(m_data));
    end
    for (int c = 0; c < N_COL; c++) begin
      if (col_rd_en[c]) begin
        served.push_back(c);
        if (fifo_cnt[c] > 0) fifo_cnt[c]--;
      end
    end
    drive_inputs();
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wait_valid(input int max);
    int k = 0;
    while (!out_valid && k < max) begin
      tick();
      k++;
    end
    check("wait_valid", 64'(out_valid), 64'd1);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int k;
    rst_n     = 1'b0;
    out_ready = 1'b0;
    for (int c = 0; c < N_COL; c++) begin
      fifo_cnt[c] = 0;
      words[c]    = '0;
    end
    drive_inputs();

    // Reset / idle.
    tick();
    chk_en = 1'b1;
    ticks(2);
    check("rst_rd_en", 64'(col_rd_en), 64'd0);
    check("rst_valid", 64'(out_valid), 64'd0);
    check("rst_data",  64'(out_data),  64'd0);
    check("rst_drop",  64'(drop_cnt),  64'd0);
    check("rst_busy",  64'(busy),      64'd0);
    rst_n = 1'b1;
    ticks(6);
    check("idle_busy",  64'(busy),      64'd0);
    check("idle_rd_en", 64'(col_rd_en), 64'd0);

    // Single hit on column 5.
    out_ready   = 1'b1;
    words[5]    = 28'h0A5C3E1;
    fifo_cnt[5] = 1;
    served.delete();
    drive_inputs();
    k = 0;
    while (col_rd_en == '0 && k < 10) begin
      tick();
      k++;
    end
    check("hit_strobe", 64'(col_rd_en), 64'h20);
    tick();
    check("hit_valid", 64'(out_valid), 64'd1);
    check("hit_data",  64'(out_data),  64'({3'd5, 28'h0A5C3E1}));
    tick();
    check("hit_accept", 64'(out_valid), 64'd0);
    check("hit_settle1", 64'(busy), 64'd1);
    tick();
    check("hit_settle2", 64'(busy), 64'd1);
    tick();
    check("hit_scan", 64'(busy), 64'd0);
    check("model_ptr6", 64'(m_ptr), 64'd6);
    check("hit_once", 64'(served.size()), 64'd1);

    // Round robin with wrap from ptr=6.
    words[7] = 28'h7000007; fifo_cnt[7] = 1;
    words[0] = 28'h0000100; fifo_cnt[0] = 1;
    words[3] = 28'h3333333; fifo_cnt[3] = 1;
    served.delete();
    drive_inputs();
    ticks(25);
    check("rr_count", 64'(served.size()), 64'd3);
    if (served.size() == 3) begin
      check("rr_first",  64'(served[0]), 64'd7);
      check("rr_second", 64'(served[1]), 64'd0);
      check("rr_third",  64'(served[2]), 64'd3);
    end
    check("model_ptr4", 64'(m_ptr), 64'd4);

    // Backpressure: columns 4 and 1 pending, downstream stalled.
    out_ready   = 1'b0;
    words[4]    = 28'h4444444; fifo_cnt[4] = 1;
    words[1]    = 28'h1234567; fifo_cnt[1] = 1;
    served.delete();
    drive_inputs();
    wait_valid(10);
    check("bp_data0", 64'(out_data), 64'({3'd4, 28'h4444444}));
    for (int i = 0; i < 10; i++) begin
      tick();
      check("bp_hold_valid", 64'(out_valid), 64'd1);
      check("bp_hold_data",  64'(out_data),  64'({3'd4, 28'h4444444}));
      check("bp_no_read",    64'(col_rd_en), 64'd0);
    end
    out_ready = 1'b1;
    tick();
    check("bp_accept", 64'(out_valid), 64'd0);
    ticks(15);
    check("bp_count", 64'(served.size()), 64'd2);
    if (served.size() == 2) begin
      check("bp_first",  64'(served[0]), 64'd4);
      check("bp_second", 64'(served[1]), 64'd1);
    end

    // Zero word on column 2: dropped and counted, then saturation.
    words[2]    = '0;
    fifo_cnt[2] = 1;
    served.delete();
    drive_inputs();
    ticks(8);
    check("zero_strobe", 64'(served.size()), 64'd1);
    check("zero_drop1",  64'(drop_cnt), 64'd1);
    check("zero_novalid", 64'(out_valid), 64'd0);
    fifo_cnt[2] = 259;
    drive_inputs();
    k = 0;
    while (fifo_cnt[2] != 0 && k < 2000) begin
      tick();
      k++;
    end
    check("zero_drained", 64'(fifo_cnt[2]), 64'd0);
    ticks(6);
    check("zero_sat", 64'(drop_cnt), 64'd255);
    check("model_sat", 64'(m_drop), 64'd255);

    // Reset while a word is held.
    out_ready   = 1'b0;
    words[6]    = 28'h6666666;
    fifo_cnt[6] = 1;
    drive_inputs();
    wait_valid(12);
    rst_n = 1'b0;
    tick();
    check("rmid_valid", 64'(out_valid), 64'd0);
    check("rmid_busy",  64'(busy),      64'd0);
    check("rmid_drop",  64'(drop_cnt),  64'd0);
    check("model_ptr0", 64'(m_ptr), 64'd0);
    rst_n     = 1'b1;
    out_ready = 1'b1;
    ticks(8);
    check("rmid_gone", 64'(out_valid), 64'd0);
    // Pointer must restart at 0: column 1 before column 7.
    words[1] = 28'h0111111; fifo_cnt[1] = 1;
    words[7] = 28'h0777777; fifo_cnt[7] = 1;
    served.delete();
    drive_inputs();
    ticks(16);
    check("rmid_count", 64'(served.size()), 64'd2);
    if (served.size() == 2) begin
      check("rmid_first",  64'(served[0]), 64'd1);
      check("rmid_second", 64'(served[1]), 64'd7);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
